// File: rtl/stage_pipe_pkg.sv
// Shared definitions for the execute/memory stage buffer.
// Holds the width and valid-flag position of the full pipeline state word,
// a packed view of that word, and a helper that sizes the buffer pointers.
package stage_pipe_pkg;

  localparam int BIG_STATE_W         = 289;
  localparam int BIG_STATE_VALID_BIT = 128;

  // Pipeline state word: control fields above the valid flag, data below it.
  typedef struct packed {
    logic [BIG_STATE_W-BIG_STATE_VALID_BIT-2:0] ctrl;
    logic                                       valid;
    logic [BIG_STATE_VALID_BIT-1:0]             data;
  } big_state_t;

  // A single-entry buffer still needs a 1-bit pointer to stay legal.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stage_pipe_mem.sv
// Storage array for stage_pipe_buf: DEPTH x DATA_W registers, one write port
// and one asynchronous read port. Contents are not reset.
//   clk   - clock
//   we    - write enable
//   waddr - write index
//   wdata - write payload
//   raddr - read index
//   rdata - payload at raddr
module stage_pipe_mem
  import stage_pipe_pkg::*;
#(
  parameter int DATA_W = BIG_STATE_W,
  parameter int DEPTH  = 2,
  localparam int PTR_W = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stage_pipe_buf.sv
// Elastic buffer between pipeline stages. A circular FIFO of DEPTH entries
// with valid/ready handshakes on both sides, optional dropping of bubble
// words (pipeline valid flag clear), flush on branch redirect, and a
// saturating counter of cycles in which the producer was held off.
//   clk       - clock, all state on the rising edge
//   reset_n   - asynchronous active-low reset
//   in_valid  - producer offers in_data
//   in_ready  - buffer can accept (depends on state only)
//   in_data   - producer payload
//   out_valid - head entry present
//   out_ready - consumer accepts head
//   out_data  - head payload, zero when empty
//   flush     - discard all buffered and incoming words
//   occupancy - current entry count
//   stall_cnt - saturating count of stalled producer cycles
module stage_pipe_buf
  import stage_pipe_pkg::*;
#(
  parameter int DATA_W       = BIG_STATE_W,
  parameter int DEPTH        = 2,
  parameter int DROP_BUBBLES = 1,
  parameter int VALID_BIT    = BIG_STATE_VALID_BIT,
  parameter int CNT_W        = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int PTR_W = ptr_width(DEPTH);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH-1);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic [CNT_W-1:0]  stall_q;
  logic [DATA_W-1:0] rd_data;
  logic              push_hs;
  logic              store;
  logic              pop;

  // Explicit compare-and-wrap so non-power-of-2 depths wrap at DEPTH-1.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign in_ready  = (occ < DEPTH_OCC);
  assign out_valid = (occ != '0);
  assign out_data  = out_valid ? rd_data : '0;
  assign occupancy = occ;
  assign stall_cnt = stall_q;

  // A bubble still completes the handshake; it is simply not written.
  assign push_hs = in_valid && in_ready && !flush;
  assign store   = push_hs && ((DROP_BUBBLES == 0) || in_data[VALID_BIT]);
  assign pop     = out_valid && out_ready;

  stage_pipe_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (store),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (store) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({store, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Stall history survives flush; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (in_valid && !in_ready) begin
      stall_q <= sat_inc(stall_q);
    end
  end

endmodule

// File: tb/tb_stage_pipe_buf.sv
// Scoreboard bench for stage_pipe_buf. Two instances share one stimulus
// stream: u0 (DEPTH=2, bubbles dropped, 16-bit stall counter) and
// u1 (DEPTH=3, bubbles stored, 3-bit stall counter to reach saturation).
module tb_stage_pipe_buf;
  import stage_pipe_pkg::*;

  typedef logic [BIG_STATE_W-1:0] word_t;

  logic  clk = 1'b0;
  logic  reset_n = 1'b0;
  logic  in_valid = 1'b0;
  logic  out_ready = 1'b0;
  logic  flush = 1'b0;
  word_t in_data = '0;

  logic        ir0, ov0, ir1, ov1;
  word_t       od0, od1;
  logic [1:0]  occ0, occ1;
  logic [15:0] st0;
  logic [2:0]  st1;

  int errors = 0;
  int checks = 0;

  word_t exp_q [2][$];
  int    stall_m [2];

  always #5 clk = ~clk;

  stage_pipe_buf #(
    .DATA_W(BIG_STATE_W), .DEPTH(2), .DROP_BUBBLES(1),
    .VALID_BIT(BIG_STATE_VALID_BIT), .CNT_W(16)
  ) u0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .flush(flush), .occupancy(occ0), .stall_cnt(st0)
  );

  stage_pipe_buf #(
    .DATA_W(BIG_STATE_W), .DEPTH(3), .DROP_BUBBLES(0),
    .VALID_BIT(BIG_STATE_VALID_BIT), .CNT_W(3)
  ) u1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .flush(flush), .occupancy(occ1), .stall_cnt(st1)
  );

  task automatic chk(input string nm, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic word_t rand_word(input bit vbit);
    word_t w;
    w = '0;
    for (int i = 0; i < 10; i++) begin
      w = {w[BIG_STATE_W-33:0], 32'($urandom)};
    end
    w[BIG_STATE_VALID_BIT] = vbit;
    return w;
  endfunction

  // Compare one instance against its model, then advance the model by the
  // transfer that the coming rising edge will perform.
  task automatic mon(input int id, input int depth, input int smax, input bit drop,
                     input int occ, input bit ir, input bit ov, input word_t od,
                     input int sc);
    int sz;
    bit rdy;
    sz  = exp_q[id].size();
    rdy = (sz < depth);
    chk($sformatf("occ%0d", id), word_t'(occ), word_t'(sz));
    chk($sformatf("in_ready%0d", id), word_t'(ir), word_t'(rdy));
    chk($sformatf("out_valid%0d", id), word_t'(ov), word_t'(sz != 0));
    chk($sformatf("out_data%0d", id), od, (sz != 0) ? exp_q[id][0] : '0);
    chk($sformatf("stall%0d", id), word_t'(sc), word_t'(stall_m[id]));
    if (sz != 0 && out_ready) void'(exp_q[id].pop_front());
    if (flush) exp_q[id].delete();
    else if (in_valid && rdy && (!drop || in_data[BIG_STATE_VALID_BIT]))
      exp_q[id].push_back(in_data);
    if (in_valid && !rdy && stall_m[id] < smax) stall_m[id]++;
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        exp_q[k].delete();
        stall_m[k] = 0;
      end
      chk("rst_occ0", word_t'(occ0), '0);
      chk("rst_ready0", word_t'(ir0), word_t'(1));
      chk("rst_data1", od1, '0);
      chk("rst_stall1", word_t'(st1), '0);
    end else begin
      mon(0, 2, 65535, 1'b1, int'(occ0), ir0, ov0, od0, int'(st0));
      mon(1, 3, 7, 1'b0, int'(occ1), ir1, ov1, od1, int'(st1));
    end
  end

  task automatic cyc(input bit v, input word_t d, input bit ordy, input bit fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cyc();
    cyc($urandom_range(0, 3) != 0, rand_word($urandom_range(0, 4) != 0),
        $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
  endtask

  task automatic reset_checks();
    chk("async_occ0", word_t'(occ0), '0);
    chk("async_occ1", word_t'(occ1), '0);
    chk("async_valid0", word_t'(ov0), '0);
    chk("async_data0", od0, '0);
    chk("async_data1", od1, '0);
    chk("async_ready0", word_t'(ir0), word_t'(1));
    chk("async_ready1", word_t'(ir1), word_t'(1));
    chk("async_stall0", word_t'(st0), '0);
    chk("async_stall1", word_t'(st1), '0);
  endtask

  initial begin
    word_t a, b;
    repeat (3) @(posedge clk);
    #1;
    reset_checks();
    reset_n = 1'b1;

    // Fill u0 with A and B, then hold the producer off for three cycles.
    a = '0;
    a[BIG_STATE_VALID_BIT] = 1'b1;
    a[15:0] = 16'h1000;
    b = rand_word(1'b1);
    cyc(1'b1, a, 1'b0, 1'b0);
    cyc(1'b1, b, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, rand_word(1'b1), 1'b0, 1'b0);
    chk("fill_occ", word_t'(occ0), word_t'(2));
    chk("fill_ready", word_t'(ir0), '0);
    chk("fill_data", od0, a);
    chk("fill_stall", word_t'(st0), word_t'(3));

    // Flush with a push and a pop offered in the same cycle.
    cyc(1'b1, rand_word(1'b1), 1'b1, 1'b1);
    chk("flush_occ", word_t'(occ0), '0);
    chk("flush_valid", word_t'(ov0), '0);
    chk("flush_data", od0, '0);

    // Bubble word: dropped by u0, stored by u1.
    cyc(1'b1, rand_word(1'b0), 1'b0, 1'b0);
    chk("bubble_occ0", word_t'(occ0), '0);
    chk("bubble_occ1", word_t'(occ1), word_t'(1));
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);

    // Continuous stream with the consumer always ready.
    for (int i = 0; i < 100; i++) cyc(1'b1, rand_word(1'b1), 1'b1, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);

    // Random traffic, including flushes and pointer wrap on DEPTH=3.
    for (int i = 0; i < 300; i++) rand_cyc();

    // Hold the producer against a full buffer past u1's counter limit.
    for (int i = 0; i < 12; i++) cyc(1'b1, rand_word(1'b1), 1'b0, 1'b0);
    chk("sat_stall1", word_t'(st1), word_t'(7));

    // Reset in the middle of traffic.
    for (int i = 0; i < 10; i++) rand_cyc();
    cyc(1'b1, rand_word(1'b1), 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    reset_checks();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) rand_cyc();
    repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
